// File: rtl/push_button_pkg.sv
// Shared types and default timing for the push-button conditioner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package push_button_pkg;

    typedef enum logic [2:0] {
        ST_RELEASED,
        ST_PRESS_DEB,
        ST_HELD,
        ST_LONG_HELD,
        ST_REL_DEB
    } btn_state_t;

    localparam int DEF_N_BTN         = 4;
    localparam int DEF_DEB_CYCLES    = 500000;
    localparam int DEF_LONG_CYCLES   = 50000000;
    localparam int DEF_REPEAT_CYCLES = 10000000;

    // Counter width for a terminal count of n; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/push_button_conditioner_if.sv
// Bundle of raw button pins and conditioned level/event outputs.
// Latency: n/a (wires only).
// Backpressure: none; pulses are fire-and-forget single-cycle events.
interface push_button_conditioner_if
    import push_button_pkg::*;
#(
    parameter int N_BTN = DEF_N_BTN
);
    logic [N_BTN-1:0] push_in;
    logic [N_BTN-1:0] pressed;
    logic [N_BTN-1:0] press_p;
    logic [N_BTN-1:0] release_p;
    logic [N_BTN-1:0] long_p;
    logic [N_BTN-1:0] repeat_p;

    modport master (
        output push_in,
        input  pressed, press_p, release_p, long_p, repeat_p
    );

    modport slave (
        input  push_in,
        output pressed, press_p, release_p, long_p, repeat_p
    );
endinterface

// File: rtl/push_button_channel.sv
// One button: 2-flop synchroniser, debounce FSM, hold/repeat timing.
// Latency: stable pin change -> registered level/pulse after DEB_CYCLES+3 edges.
// Backpressure: none; outputs are registered single-cycle pulses.
module push_button_channel
    import push_button_pkg::*;
#(
    parameter int ACTIVE_LOW    = 1,
    parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic pressed,
    output logic press_p,
    output logic release_p,
    output logic long_p,
    output logic repeat_p
);
    localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int DW       = cnt_width(DEB_CYCLES);
    localparam int HW       = cnt_width(HOLD_MAX);

    localparam logic          IDLE_LVL  = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          s;
    btn_state_t    state;
    btn_state_t    ret;
    logic [DW-1:0] deb_cnt;
    logic [HW-1:0] hold_cnt;

    // Bring the asynchronous pin into the clock domain; reset to the idle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= IDLE_LVL;
            sync2 <= IDLE_LVL;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
        end
    end

    // Active-high view of the synchronised pin.
    assign s = sync2 ^ IDLE_LVL;

    // Debounce/hold FSM with saturating counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RELEASED;
            ret       <= ST_HELD;
            deb_cnt   <= '0;
            hold_cnt  <= '0;
            pressed   <= 1'b0;
            press_p   <= 1'b0;
            release_p <= 1'b0;
            long_p    <= 1'b0;
            repeat_p  <= 1'b0;
        end else begin
            press_p   <= 1'b0;
            release_p <= 1'b0;
            long_p    <= 1'b0;
            repeat_p  <= 1'b0;
            case (state)
                ST_RELEASED: begin
                    if (s) begin
                        state   <= ST_PRESS_DEB;
                        deb_cnt <= '0;
                    end
                end
                ST_PRESS_DEB: begin
                    if (!s) begin
                        state <= ST_RELEASED;
                    end else if (deb_cnt == DEB_LAST) begin
                        state    <= ST_HELD;
                        press_p  <= 1'b1;
                        pressed  <= 1'b1;
                        hold_cnt <= '0;
                    end else if (deb_cnt != '1) begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!s) begin
                        state   <= ST_REL_DEB;
                        ret     <= ST_HELD;
                        deb_cnt <= '0;
                    end else if (hold_cnt == LONG_LAST) begin
                        state    <= ST_LONG_HELD;
                        long_p   <= 1'b1;
                        hold_cnt <= '0;
                    end else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_LONG_HELD: begin
                    if (!s) begin
                        state   <= ST_REL_DEB;
                        ret     <= ST_LONG_HELD;
                        deb_cnt <= '0;
                    end else if (hold_cnt == REP_LAST) begin
                        repeat_p <= 1'b1;
                        hold_cnt <= '0;
                    end else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_REL_DEB: begin
                    // hold_cnt is left untouched here so a glitch only pauses the hold timer.
                    if (s) begin
                        state <= ret;
                    end else if (deb_cnt == DEB_LAST) begin
                        state     <= ST_RELEASED;
                        release_p <= 1'b1;
                        pressed   <= 1'b0;
                    end else if (deb_cnt != '1) begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                default: state <= ST_RELEASED;
            endcase
        end
    end
endmodule

// File: rtl/push_button_conditioner.sv
// N independent button conditioners feeding the PWM/LED controller.
// Latency: DEB_CYCLES+3 edges from a stable pin change to PRESSED/PRESS_P/RELEASE_P.
// Backpressure: none; consumers must sample single-cycle pulses every cycle.
module push_button_conditioner
    import push_button_pkg::*;
#(
    parameter int N_BTN         = DEF_N_BTN,
    parameter int ACTIVE_LOW    = 1,
    parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic                           clk,
    input  logic                           rst,
    push_button_conditioner_if.slave       bus
);
    if (N_BTN < 1) begin : g_bad_n_btn
        $error("N_BTN must be >= 1");
    end
    if (DEB_CYCLES < 2) begin : g_bad_deb
        $error("DEB_CYCLES must be >= 2");
    end
    if (LONG_CYCLES < 1) begin : g_bad_long
        $error("LONG_CYCLES must be >= 1");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_rep
        $error("REPEAT_CYCLES must be >= 1");
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        push_button_channel #(
            .ACTIVE_LOW    (ACTIVE_LOW),
            .DEB_CYCLES    (DEB_CYCLES),
            .LONG_CYCLES   (LONG_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .pin       (bus.push_in[i]),
            .pressed   (bus.pressed[i]),
            .press_p   (bus.press_p[i]),
            .release_p (bus.release_p[i]),
            .long_p    (bus.long_p[i]),
            .repeat_p  (bus.repeat_p[i])
        );
    end
endmodule

// File: tb/tb_push_button_conditioner.sv
// Scoreboard bench: event-level reference model vs. push_button_conditioner.
// Latency: n/a.
// Backpressure: n/a.
module tb_push_button_conditioner;
    localparam int N    = 4;
    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int REP  = 8;

    typedef struct {
        int         cyc;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] lng;
        logic [3:0] rep;
    } ev_t;

    logic clk;
    logic rst;
    push_button_conditioner_if #(.N_BTN(N)) bus ();

    push_button_conditioner #(
        .N_BTN(N), .ACTIVE_LOW(1), .DEB_CYCLES(DEB),
        .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    ev_t exp_q[$];
    logic [3:0] exp_pressed;

    // Reference model state (event-level view: runs of stable samples, counted hold edges)
    logic m_sh1 [N];
    logic m_sh2 [N];
    logic m_lev [N];
    logic m_sprev [N];
    int   m_run [N];
    int   m_k [N];

    // Observed DUT pulse history for directed timing checks
    int press_cyc [N];
    int rel_cyc [N];
    int long_cyc [N];
    int rep_cyc [N];
    int press_cnt [N];
    int rel_cnt [N];
    int long_cnt [N];
    int rep_cnt [N];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cyc=%0d)", name, act, req, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: sees the same pin/reset values the DUT samples at each edge.
    always @(posedge clk) begin
        ev_t  e;
        logic s;
        logic prev;
        cyc++;
        e.cyc = cyc;
        e.press = '0;
        e.rel = '0;
        e.lng = '0;
        e.rep = '0;
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                m_sh1[i] = 1'b0;
                m_sh2[i] = 1'b0;
                m_lev[i] = 1'b0;
                m_sprev[i] = 1'b0;
                m_run[i] = 0;
                m_k[i] = 0;
            end else begin
                s = m_sh2[i];
                m_sh2[i] = m_sh1[i];
                m_sh1[i] = ~bus.push_in[i];
                prev = m_sprev[i];
                m_run[i] = (s == prev) ? m_run[i] + 1 : 1;
                m_sprev[i] = s;
                if (s != m_lev[i] && m_run[i] == DEB + 1) begin
                    if (s) begin
                        e.press[i] = 1'b1;
                        m_k[i] = 0;
                    end else begin
                        e.rel[i] = 1'b1;
                    end
                    m_lev[i] = s;
                end else if (m_lev[i] && s && prev) begin
                    m_k[i]++;
                    if (m_k[i] == LONG)
                        e.lng[i] = 1'b1;
                    else if (m_k[i] > LONG && (m_k[i] - LONG) % REP == 0)
                        e.rep[i] = 1'b1;
                end
            end
            exp_pressed[i] = m_lev[i];
        end
        if (|{e.press, e.rel, e.lng, e.rep})
            exp_q.push_back(e);
    end

    // Monitor: compares DUT pulses against queued expectations away from the active edge.
    always @(negedge clk) begin
        ev_t  e;
        logic any;
        any = |{bus.press_p, bus.release_p, bus.long_p, bus.repeat_p};
        while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL missed_event cyc=%0d expected p=%b r=%b l=%b q=%b", e.cyc, e.press, e.rel, e.lng, e.rep);
        end
        if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.press_p !== e.press || bus.release_p !== e.rel ||
                bus.long_p !== e.lng || bus.repeat_p !== e.rep) begin
                failures++;
                $display("FAIL pulses cyc=%0d actual p=%b r=%b l=%b q=%b required p=%b r=%b l=%b q=%b",
                         cyc, bus.press_p, bus.release_p, bus.long_p, bus.repeat_p,
                         e.press, e.rel, e.lng, e.rep);
            end
        end else if (any) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pulse cyc=%0d actual p=%b r=%b l=%b q=%b required none",
                     cyc, bus.press_p, bus.release_p, bus.long_p, bus.repeat_p);
        end
        checks++;
        if (bus.pressed !== exp_pressed) begin
            failures++;
            $display("FAIL pressed cyc=%0d actual=%b required=%b", cyc, bus.pressed, exp_pressed);
        end
        for (int i = 0; i < N; i++) begin
            if (bus.press_p[i] === 1'b1)   begin press_cyc[i] = cyc; press_cnt[i]++; end
            if (bus.release_p[i] === 1'b1) begin rel_cyc[i] = cyc;   rel_cnt[i]++;   end
            if (bus.long_p[i] === 1'b1)    begin long_cyc[i] = cyc;  long_cnt[i]++;  end
            if (bus.repeat_p[i] === 1'b1)  begin rep_cyc[i] = cyc;   rep_cnt[i]++;   end
        end
    end

    // Stimulus: directed scenarios, then randomized pins with occasional resets.
    initial begin
        int t;
        int rel_snapshot;
        int cd [N];
        for (int i = 0; i < N; i++) begin
            press_cyc[i] = -1; rel_cyc[i] = -1; long_cyc[i] = -1; rep_cyc[i] = -1;
            press_cnt[i] = 0;  rel_cnt[i] = 0;  long_cnt[i] = 0;  rep_cnt[i] = 0;
            cd[i] = 0;
        end
        rst = 1'b1;
        bus.push_in = '1;
        step(3);
        check("reset_outputs", int'({bus.pressed, bus.press_p, bus.release_p, bus.long_p, bus.repeat_p}), 0);
        rst = 1'b0;
        step(3);

        // Clean press on button 0
        t = cyc;
        bus.push_in[0] = 1'b0;
        step(9);
        check("clean_press_cyc", press_cyc[0], t + 7);
        check("clean_press_cnt", press_cnt[0], 1);
        check("clean_pressed", int'(bus.pressed[0]), 1);
        check("clean_no_other", rel_cnt[0] + long_cnt[0] + rep_cnt[0], 0);

        // Bounce on button 1, ending held
        t = cyc;
        for (int k = 0; k < 15; k++) begin
            bus.push_in[1] = ~bus.push_in[1];
            t = cyc;
            step(2);
        end
        step(10);
        check("bounce_press_cyc", press_cyc[1], t + 7);
        check("bounce_press_cnt", press_cnt[1], 1);

        // Long press and repeats on button 2, then release
        t = cyc;
        bus.push_in[2] = 1'b0;
        step(54);
        check("long_cyc", long_cyc[2], t + 27);
        check("repeat_cnt", rep_cnt[2], 3);
        check("repeat_last_cyc", rep_cyc[2], t + 51);
        t = cyc;
        bus.push_in[2] = 1'b1;
        step(9);
        check("release_cyc", rel_cyc[2], t + 7);
        check("release_pressed", int'(bus.pressed[2]), 0);
        check("release_no_extra_repeat", rep_cnt[2], 3);

        // Release glitch in HELD on button 3 pauses the hold timer
        t = cyc;
        bus.push_in[3] = 1'b0;
        step(10);
        bus.push_in[3] = 1'b1;
        step(2);
        bus.push_in[3] = 1'b0;
        step(22);
        check("glitch_long_cyc", long_cyc[3], t + 30);
        check("glitch_no_release", rel_cnt[3], 0);
        check("glitch_press_cnt", press_cnt[3], 1);

        // Release everything
        bus.push_in = '1;
        step(12);
        check("all_released", int'(bus.pressed), 0);

        // Simultaneous press on all buttons
        t = cyc;
        bus.push_in = '0;
        step(9);
        for (int i = 0; i < N; i++)
            check($sformatf("simul_press_cyc%0d", i), press_cyc[i], t + 7);

        // Reset while in LONG_HELD with buttons still held
        step(21);
        rel_snapshot = rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3];
        rst = 1'b1;
        step(1);
        check("midreset_outputs", int'({bus.pressed, bus.press_p, bus.release_p, bus.long_p, bus.repeat_p}), 0);
        rst = 1'b0;
        t = cyc;
        step(9);
        check("midreset_no_release", rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3], rel_snapshot);
        for (int i = 0; i < N; i++)
            check($sformatf("redetect_press_cyc%0d", i), press_cyc[i], t + 7);

        // Randomized mix of bounce, short and long holds
        repeat (4000) begin
            @(negedge clk);
            rst = ($urandom_range(0, 599) == 0);
            for (int i = 0; i < N; i++) begin
                if (cd[i] == 0) begin
                    bus.push_in[i] = ~bus.push_in[i];
                    cd[i] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : int'($urandom_range(5, 70));
                end else begin
                    cd[i]--;
                end
            end
        end
        rst = 1'b0;
        bus.push_in = '1;
        step(20);
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
